// File: rtl/glip_uart_egress_sched_if.sv
// Handshake bundle between the egress FIFO / flow-control logic, the scheduler and the UART transmitter.
interface glip_uart_egress_sched_if #(
  parameter int TX_CREDIT_WIDTH = 16
);
  logic [7:0]                 in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic                       credit_req;
  logic [15:0]                credit_value;
  logic                       credit_ack;
  logic                       grant_valid;
  logic [TX_CREDIT_WIDTH-1:0] grant_value;
  logic [7:0]                 out_data;
  logic                       out_enable;
  logic                       out_done;
  logic [TX_CREDIT_WIDTH-1:0] tx_credit;
  logic                       busy;

  modport master (
    output in_data, in_valid, credit_req, credit_value, grant_valid, grant_value, out_done,
    input  in_ready, credit_ack, out_data, out_enable, tx_credit, busy
  );

  modport slave (
    input  in_data, in_valid, credit_req, credit_value, grant_valid, grant_value, out_done,
    output in_ready, credit_ack, out_data, out_enable, tx_credit, busy
  );
endinterface

// File: rtl/glip_uart_egress_sched.sv
// Shares the UART transmitter between the credit-gated egress data stream
// and credit-return messages; escape bytes in the data stream are doubled.
//
// state     | meaning
// IDLE      | no byte offered; arbitrate credit message vs data byte
// DATA      | sending latched data byte
// DATA_ESC2 | sending the duplicate ESCAPE of an escaped data byte
// CRD_ESC   | credit message: ESCAPE
// CRD_CODE  | credit message: CREDIT_CODE
// CRD_HI    | credit message: credit[15:8]
// CRD_LO    | credit message: credit[7:0]
module glip_uart_egress_sched #(
  parameter logic [7:0] ESCAPE          = 8'hFE,
  parameter logic [7:0] CREDIT_CODE     = 8'h01,
  parameter int         TX_CREDIT_WIDTH = 16
) (
  input logic                     clk,
  input logic                     rst,
  glip_uart_egress_sched_if.slave bus
);
  localparam int CW = TX_CREDIT_WIDTH;

  typedef enum logic [2:0] {
    IDLE, DATA, DATA_ESC2, CRD_ESC, CRD_CODE, CRD_HI, CRD_LO
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      data_q;
  logic [15:0]     credit_q;
  logic [CW-1:0]   tx_credit_q, tx_credit_nxt;
  logic [CW:0]     credit_sum;
  logic            in_ready, credit_ack, out_enable;
  logic [7:0]      out_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      data_q      <= '0;
      credit_q    <= '0;
      tx_credit_q <= '0;
    end else begin
      state       <= state_nxt;
      tx_credit_q <= tx_credit_nxt;
      if (in_ready)   data_q   <= bus.in_data;
      if (credit_ack) credit_q <= bus.credit_value;
    end
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    credit_ack = 1'b0;
    out_enable = 1'b1;
    out_data   = 8'h00;
    case (state)
      IDLE: begin
        out_enable = 1'b0;
        // Credit messages win, but only here at a message boundary.
        if (bus.credit_req) begin
          credit_ack = 1'b1;
          state_nxt  = CRD_ESC;
        end else if (bus.in_valid && (tx_credit_q != '0)) begin
          in_ready  = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: begin
        out_data = data_q;
        if (bus.out_done) state_nxt = (data_q == ESCAPE) ? DATA_ESC2 : IDLE;
      end
      DATA_ESC2: begin
        out_data = ESCAPE;
        if (bus.out_done) state_nxt = IDLE;
      end
      CRD_ESC: begin
        out_data = ESCAPE;
        if (bus.out_done) state_nxt = CRD_CODE;
      end
      CRD_CODE: begin
        out_data = CREDIT_CODE;
        if (bus.out_done) state_nxt = CRD_HI;
      end
      CRD_HI: begin
        out_data = credit_q[15:8];
        if (bus.out_done) state_nxt = CRD_LO;
      end
      CRD_LO: begin
        out_data = credit_q[7:0];
        if (bus.out_done) state_nxt = IDLE;
      end
      default: begin
        out_enable = 1'b0;
        state_nxt  = IDLE;
      end
    endcase
  end

  // One extra bit catches overflow so the counter saturates instead of wrapping;
  // in_ready needs nonzero credit, so the decrement cannot underflow.
  always_comb begin
    credit_sum    = {1'b0, tx_credit_q}
                  + (bus.grant_valid ? {1'b0, bus.grant_value} : '0)
                  - {{CW{1'b0}}, in_ready};
    tx_credit_nxt = credit_sum[CW] ? '1 : credit_sum[CW-1:0];
  end

  assign bus.in_ready   = in_ready;
  assign bus.credit_ack = credit_ack;
  assign bus.out_enable = out_enable;
  assign bus.out_data   = out_data;
  assign bus.tx_credit  = tx_credit_q;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_glip_uart_egress_sched.sv
// Bench for glip_uart_egress_sched: per-cycle vector table, directed corner sequences,
// and randomized traffic against a byte-queue reference model.
module tb_glip_uart_egress_sched;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  glip_uart_egress_sched_if #(.TX_CREDIT_WIDTH(W)) bus ();

  glip_uart_egress_sched #(
    .ESCAPE(8'hFE), .CREDIT_CODE(8'h01), .TX_CREDIT_WIDTH(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        gv;
    logic [15:0] gval;
    logic        iv;
    logic [7:0]  id;
    logic        done;
    logic        e_rdy;
    logic        e_oe;
    logic [7:0]  e_od;
    logic [15:0] e_tx;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.credit_req = 1'b0;
    bus.credit_value = 16'h0000; bus.grant_valid = 1'b0; bus.grant_value = '0;
    bus.out_done = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents out_done for one cycle while checking the byte being offered.
  task automatic tx_byte(input string name, input logic [7:0] exp);
    bus.out_done = 1'b1;
    #1;
    chk({name, "_oe"}, 32'(bus.out_enable), 32'd1);
    chk({name, "_data"}, 32'(bus.out_data), 32'(exp));
    step();
    bus.out_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("rst_oe", 32'(bus.out_enable), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_ack", 32'(bus.credit_ack), 32'd0);
    chk("rst_tx_credit", 32'(bus.tx_credit), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reference model: queue of bytes still owed to the transmitter plus a credit integer.
  logic [7:0] mq[$];
  int         m_credit;

  initial begin
    logic [31:0] r;
    logic        e_rdy, e_ack, idle;

    // Grant 3, push 11/22/33/44: 44 stalls on zero credit; then grant 5 and push an escaped FE.
    tbl[0]  = '{1'b1, 16'd3, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0};
    tbl[1]  = '{1'b0, 16'd0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 16'd3};
    tbl[2]  = '{1'b0, 16'd0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 16'd2};
    tbl[3]  = '{1'b0, 16'd0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h11, 16'd2};
    tbl[4]  = '{1'b0, 16'd0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 16'd2};
    tbl[5]  = '{1'b0, 16'd0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h22, 16'd1};
    tbl[6]  = '{1'b0, 16'd0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h00, 16'd1};
    tbl[7]  = '{1'b0, 16'd0, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 8'h33, 16'd0};
    tbl[8]  = '{1'b0, 16'd0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0};
    tbl[9]  = '{1'b1, 16'd5, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0};
    tbl[10] = '{1'b0, 16'd0, 1'b1, 8'hFE, 1'b0, 1'b1, 1'b0, 8'h00, 16'd5};
    tbl[11] = '{1'b0, 16'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFE, 16'd4};
    tbl[12] = '{1'b0, 16'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hFE, 16'd4};
    tbl[13] = '{1'b0, 16'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFE, 16'd4};
    tbl[14] = '{1'b0, 16'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hFE, 16'd4};
    tbl[15] = '{1'b0, 16'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 16'd4};

    idle_inputs();
    do_reset();

    for (int i = 0; i < 16; i++) begin
      bus.grant_valid = tbl[i].gv;
      bus.grant_value = tbl[i].gval;
      bus.in_valid    = tbl[i].iv;
      bus.in_data     = tbl[i].id;
      bus.out_done    = tbl[i].done;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_oe", i), 32'(bus.out_enable), 32'(tbl[i].e_oe));
      chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(tbl[i].e_oe));
      chk($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(tbl[i].e_od));
      chk($sformatf("vec%0d_tx_credit", i), 32'(bus.tx_credit), 32'(tbl[i].e_tx));
      chk($sformatf("vec%0d_ack", i), 32'(bus.credit_ack), 32'd0);
      step();
    end
    idle_inputs();

    // Credit message pre-empts pending data at the boundary; value is latched on ack.
    bus.credit_req = 1'b1; bus.credit_value = 16'h07D0;
    bus.in_valid = 1'b1; bus.in_data = 8'h55;
    #1;
    chk("pri_ack", 32'(bus.credit_ack), 32'd1);
    chk("pri_ready", 32'(bus.in_ready), 32'd0);
    step();
    bus.credit_req = 1'b0; bus.credit_value = 16'hBEEF;
    tx_byte("pri_esc", 8'hFE);
    tx_byte("pri_code", 8'h01);
    tx_byte("pri_hi", 8'h07);
    tx_byte("pri_lo", 8'hD0);
    #1;
    chk("pri_gap_oe", 32'(bus.out_enable), 32'd0);
    chk("pri_data_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    tx_byte("pri_data", 8'h55);
    #1;
    chk("pri_tx_credit", 32'(bus.tx_credit), 32'd3);
    step();

    // Credit request arriving mid escape pair waits for the pair to finish.
    bus.in_valid = 1'b1; bus.in_data = 8'hFE;
    #1;
    chk("esc_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    tx_byte("esc_first", 8'hFE);
    bus.credit_req = 1'b1; bus.credit_value = 16'h1234;
    #1;
    chk("esc_ack_blocked", 32'(bus.credit_ack), 32'd0);
    chk("esc_second_held", 32'(bus.out_data), 32'hFE);
    step();
    tx_byte("esc_second", 8'hFE);
    #1;
    chk("esc_gap_oe", 32'(bus.out_enable), 32'd0);
    chk("esc_ack", 32'(bus.credit_ack), 32'd1);
    step();
    bus.credit_req = 1'b0;
    tx_byte("esc_crd_esc", 8'hFE);
    tx_byte("esc_crd_code", 8'h01);
    tx_byte("esc_crd_hi", 8'h12);
    tx_byte("esc_crd_lo", 8'h34);

    // Saturation, then simultaneous grant and consume.
    do_reset();
    bus.grant_valid = 1'b1; bus.grant_value = 16'hFFFE;
    step();
    bus.grant_value = 16'd5;
    #1;
    chk("sat_before", 32'(bus.tx_credit), 32'hFFFE);
    step();
    bus.grant_valid = 1'b0;
    #1;
    chk("sat_after", 32'(bus.tx_credit), 32'hFFFF);
    do_reset();
    bus.grant_valid = 1'b1; bus.grant_value = 16'd1;
    step();
    bus.grant_value = 16'd2; bus.in_valid = 1'b1; bus.in_data = 8'h77;
    #1;
    chk("sim_ready", 32'(bus.in_ready), 32'd1);
    chk("sim_before", 32'(bus.tx_credit), 32'd1);
    step();
    bus.grant_valid = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk("sim_after", 32'(bus.tx_credit), 32'd2);
    step();
    tx_byte("sim_data", 8'h77);

    // Asynchronous reset in the middle of a credit message.
    do_reset();
    bus.credit_req = 1'b1; bus.credit_value = 16'hABCD;
    bus.grant_valid = 1'b1; bus.grant_value = 16'd9;
    #1;
    chk("arst_ack", 32'(bus.credit_ack), 32'd1);
    step();
    bus.credit_req = 1'b0; bus.grant_valid = 1'b0;
    tx_byte("arst_esc", 8'hFE);
    tx_byte("arst_code", 8'h01);
    #1;
    chk("arst_hi", 32'(bus.out_data), 32'hAB);
    rst = 1'b1;
    #1;
    chk("arst_oe", 32'(bus.out_enable), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_tx_credit", 32'(bus.tx_credit), 32'd0);
    step();
    step();
    rst = 1'b0;
    bus.credit_req = 1'b1; bus.credit_value = 16'h5A3C;
    #1;
    chk("arst_new_ack", 32'(bus.credit_ack), 32'd1);
    step();
    bus.credit_req = 1'b0;
    tx_byte("arst_new_esc", 8'hFE);
    tx_byte("arst_new_code", 8'h01);
    tx_byte("arst_new_hi", 8'h5A);
    tx_byte("arst_new_lo", 8'h3C);
    #1;
    chk("arst_new_idle", 32'(bus.out_enable), 32'd0);
    step();

    // Randomized traffic against the reference model.
    do_reset();
    mq.delete();
    m_credit = 0;
    for (int c = 0; c < 4000; c++) begin
      r = $urandom; bus.credit_req   = (r[3:0] == 4'd0);
      r = $urandom; bus.in_valid     = r[0];
      bus.in_data                    = (r[2:1] == 2'd0) ? 8'hFE : r[15:8];
      r = $urandom; bus.credit_value = r[15:0];
      r = $urandom; bus.grant_valid  = (r[2:0] == 3'd0);
      bus.grant_value                = (r[8:3] == 6'd0) ? r[31:16] : {14'd0, r[10:9]};
      r = $urandom; bus.out_done     = (r[1:0] == 2'd0);
      #1;
      idle  = (mq.size() == 0);
      e_ack = idle && bus.credit_req;
      e_rdy = idle && !bus.credit_req && bus.in_valid && (m_credit != 0);
      chk("rnd_ready", 32'(bus.in_ready), 32'(e_rdy));
      chk("rnd_ack", 32'(bus.credit_ack), 32'(e_ack));
      chk("rnd_oe", 32'(bus.out_enable), 32'(!idle));
      chk("rnd_busy", 32'(bus.busy), 32'(!idle));
      chk("rnd_data", 32'(bus.out_data), idle ? 32'd0 : 32'(mq[0]));
      chk("rnd_tx_credit", 32'(bus.tx_credit), 32'(m_credit));
      m_credit = m_credit + (bus.grant_valid ? int'(bus.grant_value) : 0) - (e_rdy ? 1 : 0);
      if (m_credit > 65535) m_credit = 65535;
      if (!idle && bus.out_done) void'(mq.pop_front());
      if (e_ack) begin
        mq.push_back(8'hFE);
        mq.push_back(8'h01);
        mq.push_back(bus.credit_value[15:8]);
        mq.push_back(bus.credit_value[7:0]);
      end
      if (e_rdy) begin
        mq.push_back(bus.in_data);
        if (bus.in_data == 8'hFE) mq.push_back(8'hFE);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
